// File: rtl/mext_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: operation codes,
// FSM state encoding and the default iteration count.
package mext_sequencer_pkg;

  localparam int MEXT_ITER = 32;

  typedef enum logic [1:0] {
    m_mul = 2'd0,
    m_div = 2'd1,
    m_rem = 2'd2
  } m_ops;

  typedef logic [1:0] mext_state_t;

  localparam mext_state_t ST_IDLE = 2'd0;
  localparam mext_state_t ST_CALC = 2'd1;
  localparam mext_state_t ST_FIX  = 2'd2;
  localparam mext_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mext_iter_core.sv
// Radix-2 shift-add multiply / restoring divide step on unsigned magnitudes.
// Multiply leaves the product in {acc_hi, acc_lo}; divide leaves remainder in acc_hi, quotient in acc_lo.
module mext_iter_core
  import mext_sequencer_pkg::*;
#(
  parameter int WIDTH = MEXT_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic [WIDTH-1:0] b_q;
  logic             is_div_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  // NOTE: every signal is assigned on every path through this block; leaving one out would infer a latch.
  always_comb begin
    add_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? b_q : {WIDTH{1'b0}})};
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (is_div_q) begin
      // A clear sign bit means the trial subtraction fits: keep it and shift in a 1.
      if (!rem_diff[WIDTH]) begin
        next_hi = rem_diff[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = rem_shift[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = add_sum[WIDTH:1];
      next_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // NOTE: state updates use <= so both accumulators read their pre-edge values; = would chain them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
    end else if (load) begin
      acc_hi   <= '0;
      acc_lo   <= a_mag;
      b_q      <= b_mag;
      is_div_q <= is_div;
    end else if (step) begin
      acc_hi   <= next_hi;
      acc_lo   <= next_lo;
    end
  end

endmodule

// File: rtl/mext_sequencer.sv
// Iterative RV32M MUL/MULH*/DIV*/REM* sequencer: stalls EX while running, returns mu/ml.
// Optional one-entry result cache enabled by defining MEXT_RESULT_CACHE_EN.
module mext_sequencer
  import mext_sequencer_pkg::*;
#(
  parameter int WIDTH = MEXT_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  m_ops             mulop,
  input  logic             rs1_signed,
  input  logic             rs2_signed,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mu,
  output logic [WIDTH-1:0] ml
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mext_state_t      state;
  logic [CW-1:0]    count;
  m_ops             op_q;
  logic             sa_q, sb_q;

  logic             sa, sb, div_class;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] spec_hi, spec_lo;
  logic             accept, load, cache_hit;
  logic [WIDTH-1:0] hit_hi, hit_lo;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  // hi carries the product high word or the remainder; only m_rem swaps it onto ml.
  function automatic logic [2*WIDTH-1:0] pick(input m_ops op, input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] lo);
    return (op == m_rem) ? {lo, hi} : {hi, lo};
  endfunction

  assign sa        = rs1_signed & rs1_data[WIDTH-1];
  assign sb        = rs2_signed & rs2_data[WIDTH-1];
  assign mag1      = sa ? -rs1_data : rs1_data;
  assign mag2      = sb ? -rs2_data : rs2_data;
  assign div_class = (mulop != m_mul);
  assign div_zero  = (rs2_data == '0);
  assign div_ovf   = sa & rs2_signed & (rs2_data == '1) & (rs1_data == MIN_NEG);
  assign special   = div_class & (div_zero | div_ovf);
  assign spec_lo   = div_zero ? '1 : MIN_NEG;
  assign spec_hi   = div_zero ? rs1_data : '0;

  assign accept = (state == ST_IDLE) & start & ~flush;
  assign load   = accept & ~special & ~cache_hit;
  assign stall  = start & ~done;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  mext_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (state == ST_CALC),
    .is_div (div_class),
    .a_mag  (div_class ? mag1 : mag2),
    .b_mag  (div_class ? mag2 : mag1),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (sa_q ^ sb_q) prod = -prod;
    if (op_q == m_mul) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else begin
      fix_hi = sa_q ? -acc_hi : acc_hi;
      fix_lo = (sa_q ^ sb_q) ? -acc_lo : acc_lo;
    end
  end

`ifdef MEXT_RESULT_CACHE_EN
  logic             c_valid, c_s1, c_s2, c_div;
  logic [WIDTH-1:0] c_rs1, c_rs2, c_hi, c_lo;
  logic             k_s1, k_s2;
  logic [WIDTH-1:0] k_rs1, k_rs2;

  assign cache_hit = c_valid & (c_rs1 == rs1_data) & (c_rs2 == rs2_data) &
                     (c_s1 == rs1_signed) & (c_s2 == rs2_signed) & (c_div == div_class);
  assign hit_hi    = c_hi;
  assign hit_lo    = c_lo;

  // NOTE: the key and payload are reset together with the valid bit, so nothing stale survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_s1    <= 1'b0;
      c_s2    <= 1'b0;
      c_div   <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_hi    <= '0;
      c_lo    <= '0;
      k_s1    <= 1'b0;
      k_s2    <= 1'b0;
      k_rs1   <= '0;
      k_rs2   <= '0;
    end else if (accept && special) begin
      c_valid <= 1'b1;
      c_s1    <= rs1_signed;
      c_s2    <= rs2_signed;
      c_div   <= 1'b1;
      c_rs1   <= rs1_data;
      c_rs2   <= rs2_data;
      c_hi    <= spec_hi;
      c_lo    <= spec_lo;
    end else if (load) begin
      k_s1    <= rs1_signed;
      k_s2    <= rs2_signed;
      k_rs1   <= rs1_data;
      k_rs2   <= rs2_data;
    end else if (state == ST_FIX && !flush) begin
      c_valid <= 1'b1;
      c_s1    <= k_s1;
      c_s2    <= k_s2;
      c_div   <= (op_q != m_mul);
      c_rs1   <= k_rs1;
      c_rs2   <= k_rs2;
      c_hi    <= fix_hi;
      c_lo    <= fix_lo;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_hi    = '0;
  assign hit_lo    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= m_mul;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      mu    <= '0;
      ml    <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= mulop;
            sa_q  <= sa;
            sb_q  <= sb;
            count <= '0;
            if (special) begin
              state    <= ST_DONE;
              {mu, ml} <= pick(mulop, spec_hi, spec_lo);
            end else if (cache_hit) begin
              state    <= ST_DONE;
              {mu, ml} <= pick(mulop, hit_hi, hit_lo);
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          state    <= ST_DONE;
          {mu, ml} <= pick(op_q, fix_hi, fix_lo);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mext_sequencer.sv
// Scoreboard bench for mext_sequencer: the driver pushes reference results, a negedge monitor checks them.
module tb_mext_sequencer;
  import mext_sequencer_pkg::*;

  logic        clk, rst_n, start, flush, rs1_signed, rs2_signed;
  m_ops        mulop;
  logic [31:0] rs1_data, rs2_data, mu, ml;
  logic        stall, busy, done;

  mext_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .mulop(mulop),
    .rs1_signed(rs1_signed), .rs2_signed(rs2_signed), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .busy(busy), .done(done), .mu(mu), .ml(ml)
  );

  typedef struct {
    logic [31:0] mu;
    logic [31:0] ml;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_err = 0, n_checks = 0;
  int          cyc = 0, stall_cnt = 0, done_cnt = 0;
  logic [31:0] last_mu = 0, last_ml = 0;
  bit          cm_valid = 0, cm_s1, cm_s2, cm_div;
  logic [31:0] cm_a, cm_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (stall) stall_cnt <= stall_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results from plain 64-bit integer arithmetic on the architectural values.
  function automatic void model(input m_ops op, input logic s1, input logic s2,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] emu, output logic [31:0] eml);
    longint va, vb, p, q, r;
    va = s1 ? longint'($signed(a)) : longint'(a);
    vb = s2 ? longint'($signed(b)) : longint'(b);
    if (op == m_mul) begin
      p   = va * vb;
      emu = p[63:32];
      eml = p[31:0];
    end else begin
      if (b == 0) begin
        q = -1;
        r = va;
      end else if (s1 && s2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = va;
        r = 0;
      end else begin
        q = va / vb;
        r = va % vb;
      end
      if (op == m_div) begin
        eml = q[31:0];
        emu = r[31:0];
      end else begin
        eml = r[31:0];
        emu = q[31:0];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("done_expected", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mu", 64'(mu), 64'(e.mu));
        check("ml", 64'(ml), 64'(e.ml));
        check("latency", 64'(cyc - e.issue), 64'(e.lat));
      end
    end
  end

  // Issues one instruction and returns in the done cycle with start still high (back-to-back ready).
  task automatic issue(input m_ops op, input logic s1, input logic s2,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   special, hit, seen;
    model(op, s1, s2, a, b, e.mu, e.ml);
    special = (op != m_mul) && (b == 0 || (s1 && s2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    hit = 1'b0;
`ifdef MEXT_RESULT_CACHE_EN
    hit = cm_valid && cm_a == a && cm_b == b && cm_s1 == s1 && cm_s2 == s2 && cm_div == (op != m_mul);
`endif
    e.lat = (special || hit) ? 1 : 34;
    cm_valid = 1'b1; cm_a = a; cm_b = b; cm_s1 = s1; cm_s2 = s2; cm_div = (op != m_mul);
    @(posedge clk); #1;
    mulop = op; rs1_signed = s1; rs2_signed = s2; rs1_data = a; rs2_data = b; start = 1'b1;
    e.issue = cyc;
    sb_q.push_back(e);
    last_mu = e.mu; last_ml = e.ml;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      check("done_timeout", 64'(seen), 64'd1);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s0, d0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; mulop = m_mul;
    rs1_signed = 1'b0; rs2_signed = 1'b0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mu", 64'(mu), 64'd0);
    check("rst_ml", 64'(ml), 64'd0);
    rst_n = 1'b1;

    s0 = stall_cnt; d0 = done_cnt;
    issue(m_mul, 0, 0, 32'd7, 32'd6);
    idle(2);
    check("mul_stall_cycles", 64'(stall_cnt - s0), 64'd34);
    check("mul_done_pulses", 64'(done_cnt - d0), 64'd1);

    issue(m_mul, 1, 1, 32'h8000_0000, 32'h8000_0000);
    issue(m_mul, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(m_div, 1, 1, 32'hFFFF_FFF9, 32'd2);
    issue(m_rem, 1, 1, 32'hFFFF_FFF9, 32'd2);
    issue(m_div, 0, 0, 32'd100, 32'd7);
    issue(m_rem, 0, 0, 32'd100, 32'd7);
    issue(m_div, 0, 0, 32'd5, 32'd0);
    issue(m_div, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(1);

    // Flush in the middle of CALC: no done, back to IDLE, results untouched.
    @(posedge clk); #1;
    mulop = m_mul; rs1_signed = 1'b0; rs2_signed = 1'b0; rs1_data = 32'd5; rs2_data = 32'd5; start = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_flush", 64'(busy), 64'd1);
    d0 = done_cnt;
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("busy_after_flush", 64'(busy), 64'd0);
    check("mu_hold_flush", 64'(mu), 64'(last_mu));
    check("ml_hold_flush", 64'(ml), 64'(last_ml));
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_no_capture", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);
    issue(m_mul, 0, 0, 32'd3, 32'd3);
    idle(1);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    mulop = m_mul; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; start = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_mu", 64'(mu), 64'd0);
    check("rst_mid_ml", 64'(ml), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cm_valid = 1'b0; last_mu = '0; last_ml = '0;

    for (int i = 0; i < 40; i++) begin
      m_ops        op, op2;
      logic        s1, s2;
      logic [31:0] a, b;
      op = m_ops'($urandom_range(0, 2));
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      a  = pick_val();
      b  = pick_val();
      issue(op, s1, s2, a, b);
      if ($urandom_range(0, 2) == 0) begin
        op2 = (op == m_div) ? m_rem : (op == m_rem) ? m_div : m_mul;
        issue(op2, s1, s2, a, b);
      end
      if ($urandom_range(0, 3) == 0) idle(2);
    end
    idle(4);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
